// File: rtl/iob_timer_sched_pkg.sv
// Shared register map and bit positions for the alarm scheduler.
package iob_timer_sched_pkg;

    localparam logic [3:0] CTRL        = 4'd0;
    localparam logic [3:0] COUNT       = 4'd1;
    localparam logic [3:0] STATUS      = 4'd2;
    localparam logic [3:0] IRQ_EN      = 4'd3;
    localparam logic [3:0] CFG_BASE    = 4'd4;
    localparam logic [3:0] CMP_BASE    = 4'd8;
    localparam logic [3:0] PERIOD_BASE = 4'd12;

    localparam int RUN      = 0;
    localparam int CLR      = 1;
    localparam int EN       = 0;
    localparam int PERIODIC = 1;

endpackage

// File: rtl/iob_timer_sched_ch.sv
// One alarm channel: deadline/period/config registers, compare,
// reload-or-disarm on a hit, and the registered match pulse.
module iob_timer_sched_ch
    import iob_timer_sched_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [W-1:0] count,
    input  logic         we_cfg,
    input  logic         we_cmp,
    input  logic         we_per,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] cmp,
    output logic [W-1:0] period,
    output logic [1:0]   cfg,
    output logic         hit,
    output logic         match
);

    logic reload;

    assign hit    = run & cfg[EN] & (count == cmp);
    assign reload = cfg[PERIODIC] & (period != '0);

    // CPU writes take priority over the automatic reload/disarm
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp    <= '0;
            period <= '0;
            cfg    <= '0;
            match  <= 1'b0;
        end else begin
            match <= hit;
            if (we_cmp)
                cmp <= wdata;
            else if (hit && reload)
                cmp <= cmp + period;
            if (we_per)
                period <= wdata;
            if (we_cfg)
                cfg <= wdata[1:0];
            else if (hit && !reload)
                cfg[EN] <= 1'b0;
        end
    end

endmodule

// File: rtl/iob_timer_sched.sv
// Multi-channel alarm scheduler: free-running timebase, CPU register
// decode, pending/irq aggregation over N_CH channel instances.
module iob_timer_sched
    import iob_timer_sched_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int N_CH          = 4,
    parameter int ADDR_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     wr,
    input  logic [COUNTER_WIDTH-1:0] data_in,
    output logic [COUNTER_WIDTH-1:0] data_out,
    output logic                     ready,
    output logic [N_CH-1:0]          match,
    output logic                     irq
);

    localparam int W = COUNTER_WIDTH;

    logic                    run;
    logic [W-1:0]            counter;
    logic [N_CH-1:0]         pending;
    logic [N_CH-1:0]         irq_en;
    logic [N_CH-1:0]         hit;
    logic [N_CH-1:0]         we_cfg, we_cmp, we_per;
    logic [N_CH-1:0][W-1:0]  cmp, period;
    logic [N_CH-1:0][1:0]    cfg;
    logic [N_CH-1:0]         w1c;
    logic [W-1:0]            rdata;
    logic                    wr_en;
    logic [1:0]              grp, idx;

    assign wr_en = valid & wr;
    assign grp   = addr[3:2];
    assign idx   = addr[1:0];
    assign irq   = |(pending & irq_en);
    assign w1c   = (wr_en && addr == STATUS) ? data_in[N_CH-1:0] : '0;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign we_cfg[i] = wr_en && grp == CFG_BASE[3:2] && idx == 2'(i);
        assign we_cmp[i] = wr_en && grp == CMP_BASE[3:2] && idx == 2'(i);
        assign we_per[i] = wr_en && grp == PERIOD_BASE[3:2] && idx == 2'(i);

        iob_timer_sched_ch #(.W(W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .count  (counter),
            .we_cfg (we_cfg[i]),
            .we_cmp (we_cmp[i]),
            .we_per (we_per[i]),
            .wdata  (data_in),
            .cmp    (cmp[i]),
            .period (period[i]),
            .cfg    (cfg[i]),
            .hit    (hit[i]),
            .match  (match[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CTRL:    rdata[RUN] = run;
            COUNT:   rdata = counter;
            STATUS:  rdata[N_CH-1:0] = pending;
            IRQ_EN:  rdata[N_CH-1:0] = irq_en;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (idx == 2'(i)) begin
                        if (grp == CFG_BASE[3:2])
                            rdata[1:0] = cfg[i];
                        else if (grp == CMP_BASE[3:2])
                            rdata = cmp[i];
                        else if (grp == PERIOD_BASE[3:2])
                            rdata = period[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run      <= 1'b0;
            counter  <= '0;
            pending  <= '0;
            irq_en   <= '0;
            ready    <= 1'b0;
            data_out <= '0;
        end else begin
            ready <= valid;
            if (valid && !wr)
                data_out <= rdata;
            // a new hit beats a same-cycle clear
            pending <= (pending & ~w1c) | hit;
            if (wr_en && addr == IRQ_EN)
                irq_en <= data_in[N_CH-1:0];
            if (wr_en && addr == CTRL) begin
                run <= data_in[RUN];
                if (data_in[CLR])
                    counter <= '0;
                else if (run)
                    counter <= counter + W'(1);
            end else if (run) begin
                counter <= counter + W'(1);
            end
        end
    end

endmodule
